// File: rtl/saxil_read_arb.sv
// saxil_read_arb: round-robin arbiter sharing one AXI-Lite read slave between two requesters
module saxil_read_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  saxil_read_arb_clk,
  input  logic                  saxil_read_arb_rst_n,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [2:0]            m0_arprot,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [2:0]            m1_arprot,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic [2:0]            s_arprot,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_nx;
  logic grant, last, pick, accept, done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0] prot_q;
  assign s_araddr = addr_q;
  assign s_arprot = prot_q;
  // state register
  always_ff @(posedge saxil_read_arb_clk or negedge saxil_read_arb_rst_n)
    if (!saxil_read_arb_rst_n) state <= IDLE;
    else state <= state_nx;
  // next state, grant selection and channel routing; arready is masked during reset so every output is 0
  always_comb begin
    state_nx   = state;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    m0_rresp   = 2'b00;
    m1_rresp   = 2'b00;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    pick       = (m0_arvalid && m1_arvalid) ? ~last : m1_arvalid;
    accept     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        accept     = m0_arvalid | m1_arvalid;
        m0_arready = saxil_read_arb_rst_n & m0_arvalid & ~pick;
        m1_arready = saxil_read_arb_rst_n & m1_arvalid & pick;
        state_nx   = accept ? ADDR : IDLE;
      end
      ADDR: begin
        s_arvalid = 1'b1;
        state_nx  = s_arready ? DATA : ADDR;
      end
      DATA: begin
        s_rready  = grant ? m1_rready : m0_rready;
        m0_rvalid = ~grant & s_rvalid;
        m1_rvalid = grant & s_rvalid;
        m0_rdata  = grant ? '0 : s_rdata;
        m1_rdata  = grant ? s_rdata : '0;
        m0_rresp  = grant ? 2'b00 : s_rresp;
        m1_rresp  = grant ? s_rresp : 2'b00;
        done      = s_rvalid & s_rready;
        state_nx  = done ? IDLE : DATA;
      end
      default: state_nx = IDLE;
    endcase
  end
  // capture the winner's request on acceptance; remember who was served when the response completes
  always_ff @(posedge saxil_read_arb_clk or negedge saxil_read_arb_rst_n)
    if (!saxil_read_arb_rst_n) begin
      grant  <= 1'b0;
      last   <= 1'b1;
      addr_q <= '0;
      prot_q <= 3'b000;
    end else begin
      if (accept) begin
        grant  <= pick;
        addr_q <= pick ? m1_araddr : m0_araddr;
        prot_q <= pick ? m1_arprot : m0_arprot;
      end
      if (done) last <= grant;
    end
endmodule

// File: tb/tb_saxil_read_arb.sv
// tb_saxil_read_arb: vector table, directed corner sequences and randomized transaction-level checks
module tb_saxil_read_arb;
  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_arvalid, m0_arready, m0_rvalid, m0_rready, m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] m0_araddr, m1_araddr, m0_rdata, m1_rdata, s_araddr, s_rdata;
  logic [2:0] m0_arprot, m1_arprot, s_arprot;
  logic [1:0] m0_rresp, m1_rresp, s_rresp;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  int checks = 0, failures = 0;

  saxil_read_arb dut (
    .saxil_read_arb_clk(clk), .saxil_read_arb_rst_n(rst_n),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arprot(m0_arprot),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arprot(m1_arprot),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, a0v, a1v;
    logic [31:0] ad0, ad1;
    logic sar, srv;
    logic [31:0] srd;
    logic [1:0] srp;
    logic r0r, r1r;
    logic [5:0] flags;
    logic [31:0] esad, e0rd, e1rd;
    logic [1:0] e0rp, e1rp;
  } vec_t;

  function automatic vec_t mk(logic rst, a0v, a1v, logic [31:0] ad0, ad1, logic sar, srv,
                              logic [31:0] srd, logic [1:0] srp, logic r0r, r1r, logic [5:0] flags,
                              logic [31:0] esad, e0rd, e1rd, logic [1:0] e0rp, e1rp);
    vec_t v;
    v.rst = rst; v.a0v = a0v; v.a1v = a1v; v.ad0 = ad0; v.ad1 = ad1; v.sar = sar; v.srv = srv;
    v.srd = srd; v.srp = srp; v.r0r = r0r; v.r1r = r1r; v.flags = flags; v.esad = esad;
    v.e0rd = e0rd; v.e1rd = e1rd; v.e0rp = e0rp; v.e1rp = e1rp;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {m0_arready, m1_arready, s_arvalid, m0_rvalid, m1_rvalid, s_rready};
  endfunction

  task automatic idle_inputs();
    m0_arvalid = 0; m1_arvalid = 0; m0_araddr = 0; m1_araddr = 0; m0_arprot = 3'd5; m1_arprot = 3'd2;
    m0_rready = 0; m1_rready = 0; s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
  endtask

  localparam logic [31:0] A = 32'hF0F0_F0F0, B = 32'h0F0F_0F0F, F = 32'hFFFF_FFFF;
  vec_t tv[13];

  logic rq_v[2], busy[2];
  logic [31:0] rq_a[2];
  logic [2:0] rq_p[2];
  logic last_m, out_v, out_w, ar_done, sp, srv_hold, acc, g, in_addr, in_data, e_srr, hs_ar, hs_r;
  logic [31:0] out_a, sp_a;
  logic [2:0] out_p;
  int done_cnt;

  initial begin
    idle_inputs();
    // flags order: m0_arready m1_arready s_arvalid m0_rvalid m1_rvalid s_rready
    tv[0]  = mk(1, 1, 1, A, B, 1, 1, 0,            2'b00, 1, 1, 6'b000000, 0, 0, 0, 0, 0);
    tv[1]  = mk(0, 1, 1, A, B, 1, 1, 32'h1111_1111, 2'b01, 1, 1, 6'b100000, 0, 0, 0, 0, 0);
    tv[2]  = mk(0, 0, 1, A, B, 1, 1, 32'h1111_1111, 2'b01, 1, 1, 6'b001000, A, 0, 0, 0, 0);
    tv[3]  = mk(0, 0, 1, A, B, 1, 1, 32'h1111_1111, 2'b01, 1, 1, 6'b000101, A, 32'h1111_1111, 0, 2'b01, 0);
    tv[4]  = mk(0, 1, 1, A, B, 1, 1, 32'h2222_2222, 2'b10, 1, 1, 6'b010000, A, 0, 0, 0, 0);
    tv[5]  = mk(0, 1, 0, A, B, 1, 1, 32'h2222_2222, 2'b10, 1, 1, 6'b001000, B, 0, 0, 0, 0);
    tv[6]  = mk(0, 1, 0, A, B, 1, 1, 32'h2222_2222, 2'b10, 1, 1, 6'b000011, B, 0, 32'h2222_2222, 0, 2'b10);
    tv[7]  = mk(0, 1, 1, A, B, 1, 1, 32'h3333_3333, 2'b11, 1, 1, 6'b100000, B, 0, 0, 0, 0);
    tv[8]  = mk(1, 1, 1, A, B, 1, 1, 32'h3333_3333, 2'b11, 1, 1, 6'b000000, 0, 0, 0, 0, 0);
    tv[9]  = mk(0, 1, 1, F, B, 1, 0, 0,            2'b00, 1, 0, 6'b100000, 0, 0, 0, 0, 0);
    tv[10] = mk(0, 0, 0, F, B, 1, 0, 0,            2'b00, 1, 0, 6'b001000, F, 0, 0, 0, 0);
    tv[11] = mk(0, 0, 0, F, B, 1, 1, 32'hDEAD_BEEF, 2'b00, 1, 0, 6'b000101, F, 32'hDEAD_BEEF, 0, 0, 0);
    tv[12] = mk(0, 0, 0, F, B, 1, 1, 32'hDEAD_BEEF, 2'b00, 1, 0, 6'b000000, F, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rst_n = !tv[i].rst; m0_arvalid = tv[i].a0v; m1_arvalid = tv[i].a1v;
      m0_araddr = tv[i].ad0; m1_araddr = tv[i].ad1; s_arready = tv[i].sar; s_rvalid = tv[i].srv;
      s_rdata = tv[i].srd; s_rresp = tv[i].srp; m0_rready = tv[i].r0r; m1_rready = tv[i].r1r;
      #1;
      chk($sformatf("vec%0d_flags", i), 32'(flags()), 32'(tv[i].flags));
      chk($sformatf("vec%0d_s_araddr", i), s_araddr, tv[i].esad);
      chk($sformatf("vec%0d_m0_rdata", i), m0_rdata, tv[i].e0rd);
      chk($sformatf("vec%0d_m1_rdata", i), m1_rdata, tv[i].e1rd);
      chk($sformatf("vec%0d_rresp", i), 32'({m0_rresp, m1_rresp}), 32'({tv[i].e0rp, tv[i].e1rp}));
    end

    // address stall: m1 wins (m0 was served last), slave withholds arready for 4 cycles
    @(negedge clk);
    idle_inputs(); m0_arvalid = 1; m0_araddr = A; m1_arvalid = 1; m1_araddr = 32'h1234_5678; m1_arprot = 3'd3;
    #1 chk("stall_accept", 32'(flags()), 32'(6'b010000));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); m1_arvalid = 0; m1_araddr = 0;
      #1 chk($sformatf("stall%0d_flags", i), 32'(flags()), 32'(6'b001000));
      chk($sformatf("stall%0d_addr", i), s_araddr, 32'h1234_5678);
      chk($sformatf("stall%0d_prot", i), 32'(s_arprot), 32'd3);
    end
    @(negedge clk); s_arready = 1;
    #1 chk("stall_release", 32'(flags()), 32'(6'b001000));
    // response backpressure from m1 for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); s_arready = 0; s_rvalid = 1; s_rdata = 32'hCAFE_F00D; s_rresp = 2'b10; m1_rready = 0;
      #1 chk($sformatf("bp%0d_flags", i), 32'(flags()), 32'(6'b000010));
      chk($sformatf("bp%0d_m1_rdata", i), m1_rdata, 32'hCAFE_F00D);
    end
    @(negedge clk); m1_rready = 1;
    #1 chk("bp_release", 32'(flags()), 32'(6'b000011));
    @(negedge clk);
    #1 chk("bp_after_idle", 32'(flags()), 32'(6'b100000));
    @(negedge clk); m0_arvalid = 0; s_rvalid = 0; s_arready = 1; m1_rready = 0;
    #1 chk("m0_addr", s_araddr, A);
    @(negedge clk); s_rvalid = 1; s_rdata = 32'h0BAD_F00D; m0_rready = 1;
    #1 chk("m0_data", m0_rdata, 32'h0BAD_F00D);
    // m1 as sole requester three times in a row
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle_inputs(); m1_arvalid = 1; m1_araddr = 32'h100 * (k + 1); s_arready = 1;
      #1 chk($sformatf("solo%0d_accept", k), 32'(flags()), 32'(6'b010000));
      @(negedge clk); m1_arvalid = 0;
      #1 chk($sformatf("solo%0d_addr", k), s_araddr, 32'h100 * (k + 1));
      @(negedge clk); s_rvalid = 1; s_rdata = 32'hA0 + k; m1_rready = 1;
      #1 chk($sformatf("solo%0d_data", k), {m1_rdata[30:0], m1_rvalid}, {31'(32'hA0 + k), 1'b1});
      chk($sformatf("solo%0d_m0", k), {m0_rdata[29:0], m0_rresp}, 32'd0);
    end

    // randomized run against a transaction-level model
    @(negedge clk); idle_inputs(); rst_n = 0;
    @(negedge clk); rst_n = 1;
    last_m = 1; out_v = 0; out_w = 0; ar_done = 0; sp = 0; srv_hold = 0; out_a = 0; out_p = 0; sp_a = 0; done_cnt = 0;
    for (int i = 0; i < 2; i++) begin rq_v[i] = 0; busy[i] = 0; rq_a[i] = 0; rq_p[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (!rq_v[i] && !busy[i] && $urandom_range(0, 2) == 0) begin
          rq_v[i] = 1; rq_a[i] = $urandom; rq_p[i] = 3'($urandom_range(0, 7));
        end
      m0_arvalid = rq_v[0]; m0_araddr = rq_a[0]; m0_arprot = rq_p[0];
      m1_arvalid = rq_v[1]; m1_araddr = rq_a[1]; m1_arprot = rq_p[1];
      m0_rready = 1'($urandom_range(0, 1)); m1_rready = 1'($urandom_range(0, 1));
      s_arready = 1'($urandom_range(0, 1));
      s_rvalid = sp && (srv_hold || $urandom_range(0, 1) == 1);
      s_rdata = ~sp_a; s_rresp = sp_a[1:0];
      #1;
      acc = !out_v && (rq_v[0] || rq_v[1]);
      g = (rq_v[0] && rq_v[1]) ? !last_m : rq_v[1];
      in_addr = out_v && !ar_done;
      in_data = out_v && ar_done;
      e_srr = in_data && (out_w ? m1_rready : m0_rready);
      chk("rnd_flags", 32'(flags()), 32'({acc && !g, acc && g, in_addr,
          in_data && !out_w && s_rvalid, in_data && out_w && s_rvalid, e_srr}));
      chk("rnd_m0_rdata", m0_rdata, (in_data && !out_w) ? ~out_a : 32'd0);
      chk("rnd_m1_rdata", m1_rdata, (in_data && out_w) ? ~out_a : 32'd0);
      chk("rnd_rresp", 32'({m0_rresp, m1_rresp}),
          32'({(in_data && !out_w) ? out_a[1:0] : 2'b00, (in_data && out_w) ? out_a[1:0] : 2'b00}));
      if (in_addr) chk("rnd_s_addr", {s_araddr[28:0], s_arprot}, {out_a[28:0], out_p});
      hs_ar = in_addr && s_arready;
      hs_r = in_data && s_rvalid && e_srr;
      if (acc) begin
        out_v = 1; out_w = g; out_a = rq_a[int'(g)]; out_p = rq_p[int'(g)]; ar_done = 0;
        rq_v[int'(g)] = 0; busy[int'(g)] = 1;
      end else if (hs_ar) begin
        ar_done = 1; sp = 1; sp_a = out_a;
      end else if (hs_r) begin
        out_v = 0; last_m = out_w; busy[int'(out_w)] = 0; sp = 0; done_cnt++;
      end
      srv_hold = s_rvalid && !hs_r;
    end
    chk("rnd_progress", 32'(done_cnt >= 50), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
